// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  localparam int DATA_BITS  = 8;
  localparam int CHK_OFS    = 2;
  localparam int PRESCALE_W = 6;
  localparam int BITCNT_W   = 4;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } uart_rx_state_t;

  // Check point sits CHK_OFS oversamples past mid-bit, where the sampler's vote is settled.
  function automatic logic [PRESCALE_W-1:0] rx_chk_point(input logic [PRESCALE_W-1:0] prescale);
    return (prescale >> 1) + PRESCALE_W'(CHK_OFS);
  endfunction
endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and bit index counter for the UART receiver.
module uart_rx_edge_bit_counter
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BITCNT_W-1:0]   bit_count,
  output logic                  wrap
);

  assign wrap = enable && (edge_count == prescale - PRESCALE_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (clear) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (wrap) begin
      edge_count <= '0;
      bit_count  <= bit_count + BITCNT_W'(1);
    end else if (enable) begin
      edge_count <= edge_count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, bit sequencing, parity/stop checks.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fsm
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  input  logic [DATA_BITS-1:0]  p_data,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BITCNT_W-1:0]   bit_count,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  uart_rx_state_t        state, state_nxt;
  logic                  wrap;
  logic                  at_chk;
  logic                  last_data_bit;
  logic                  start_det;
  logic [PRESCALE_W-1:0] chk;

  assign chk           = rx_chk_point(prescale);
  assign at_chk        = (edge_count == chk);
  assign last_data_bit = (bit_count == BITCNT_W'(DATA_BITS));
  assign start_det     = (state == RX_IDLE) && !rx_in;

  uart_rx_edge_bit_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .enable     (state != RX_IDLE),
    .clear      (state_nxt == RX_IDLE),
    .prescale   (prescale),
    .edge_count (edge_count),
    .bit_count  (bit_count),
    .wrap       (wrap)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:   if (!rx_in) state_nxt = RX_START;
      RX_START: begin
        if (at_chk && sampled_bit) state_nxt = RX_IDLE;
        else if (wrap)             state_nxt = RX_DATA;
      end
      RX_DATA: begin
        if (wrap && last_data_bit) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = par_en ? RX_PARITY : RX_STOP;
`else
          state_nxt = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (wrap) state_nxt = RX_STOP;
`endif
      // Leave at the stop check point so a back-to-back start edge is seen early.
      RX_STOP:   if (at_chk) state_nxt = RX_IDLE;
      default:   state_nxt = RX_IDLE;
    endcase
  end

  assign dat_samp_en = (state != RX_IDLE);
  assign deser_en    = (state == RX_DATA);

`ifdef UART_RX_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (start_det) begin
      par_err_q <= 1'b0;
    end else if ((state == RX_PARITY) && at_chk) begin
      par_err_q <= sampled_bit ^ (^p_data) ^ par_typ;
    end
  end

  assign par_err = par_err_q;
`else
  logic unused_par_inputs;

  assign unused_par_inputs = ^{par_en, par_typ, p_data};
  assign par_err           = 1'b0;
`endif

  // Frame acceptance uses the parity flag as it stands plus the stop bit seen now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RX_IDLE;
      stp_err     <= 1'b0;
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      state       <= state_nxt;
      data_valid  <= 1'b0;
      strt_glitch <= (state == RX_START) && at_chk && sampled_bit;
      if (start_det) begin
        stp_err <= 1'b0;
      end else if ((state == RX_STOP) && at_chk) begin
        stp_err    <= ~sampled_bit;
        data_valid <= ~par_err & sampled_bit;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm with a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_fsm;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       sampled_bit;
  logic [7:0] p_data = 8'h00;
  logic       dat_samp_en, deser_en, data_valid, par_err, stp_err, strt_glitch;
  logic [5:0] edge_count;
  logic [3:0] bit_count;

  always #5 clk = ~clk;

  // The line is clean, so the sampler's majority vote equals the line level.
  assign sampled_bit = rx_in;

  uart_rx_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .sampled_bit (sampled_bit),
    .p_data      (p_data),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .edge_count  (edge_count),
    .bit_count   (bit_count),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Neighbouring deserializer: shifts the sampled bit in, LSB first, at each check point.
  always @(posedge clk)
    if (deser_en && (edge_count == (prescale >> 1) + 6'd2))
      p_data <= {sampled_bit, p_data[7:1]};

  int         dv_total = 0, dv_t = 0, gl_total = 0, gl_t = 0, deser_total = 0;
  logic [7:0] dv_d = 8'h00;
  logic       gl_samp = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_total <= dv_total + 1;
      dv_t     <= cyc;
      dv_d     <= p_data;
    end
    if (strt_glitch) begin
      gl_total <= gl_total + 1;
      gl_t     <= cyc;
      gl_samp  <= dat_samp_en;
    end
    if (deser_en) deser_total <= deser_total + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [11:0] bits, input int first, input int n, input int p);
    for (int i = first; i < first + n; i++) begin
      rx_in = bits[i];
      repeat (p) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {dat_samp_en, deser_en, edge_count, bit_count, data_valid, par_err, stp_err, strt_glitch};
  endfunction

  // One full frame; T is the first edge that sees the start bit.
  task automatic run_frame(input string tag, input logic [7:0] d, input int p,
                           input bit pe, input bit pt, input bit pbit, input bit sbit);
    int          t0, nb, chk, dv0, gl0, ds0;
    bit          pon, exp_pe, exp_se, exp_dv;
    logic [11:0] bits;
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = pt;
    pon      = HAS_PAR && pe;
    nb       = pon ? 10 : 9;
    chk      = p / 2 + 2;
    bits     = '1;
    bits[0]  = 1'b0;
    bits[8:1] = d;
    if (pon) begin
      bits[9]  = pbit;
      bits[10] = sbit;
    end else begin
      bits[9]  = sbit;
    end
    exp_pe = pon && (((^d) ^ pbit ^ pt) != 1'b0);
    exp_se = !sbit;
    exp_dv = !exp_pe && !exp_se;
    dv0 = dv_total;
    gl0 = gl_total;
    ds0 = deser_total;
    t0  = cyc + 1;
    send_bits(bits, 0, 1, p);
    check({tag, ".flags_clr"}, {par_err, stp_err}, 0);
    send_bits(bits, 1, nb, p);
    @(negedge clk);
    #1;
    check({tag, ".dv_cnt"}, dv_total - dv0, exp_dv);
    if (exp_dv) begin
      check({tag, ".dv_time"}, dv_t, t0 + 1 + nb * p + chk);
      check({tag, ".data"}, dv_d, d);
    end
    check({tag, ".par_err"}, par_err, exp_pe);
    check({tag, ".stp_err"}, stp_err, exp_se);
    check({tag, ".deser_cyc"}, deser_total - ds0, 8 * p);
    check({tag, ".glitch"}, gl_total - gl0, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0, dv0, ds0, first_t, k, p;
    logic [7:0]  d;
    logic [11:0] bits;
    bit          pe, pt, pb, sb;

    repeat (3) @(negedge clk);
    check("reset.outs", all_outs(), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame("clean", 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1);

    run_frame("par_ok", 8'h37, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    run_frame("par_bad", 8'h37, 16, 1'b1, 1'b0, 1'b0, 1'b1);

    run_frame("stop_err", 8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("after_stop", 8'h5C, 8, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start glitch: three low cycles, then idle.
    prescale = 6'd8;
    par_en   = 1'b0;
    dv0 = dv_total;
    ds0 = deser_total;
    k   = gl_total;
    t0  = cyc + 1;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("glitch.cnt", gl_total - k, 1);
    check("glitch.time", gl_t, t0 + 1 + 6);
    check("glitch.idle", gl_samp, 0);
    check("glitch.deser", deser_total - ds0, 0);
    check("glitch.dv", dv_total - dv0, 0);
    run_frame("post_glitch", 8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back frames with continuous line timing.
    run_frame("b2b_1", 8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    first_t = dv_t;
    run_frame("b2b_2", 8'hE7, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b.spacing", dv_t - first_t, 10 * 32);

    // Reset in the middle of the data bits.
    prescale = 6'd8;
    par_en   = 1'b0;
    dv0  = dv_total;
    bits = {3'b111, 8'hC3, 1'b0};
    send_bits(bits, 0, 5, 8);
    for (k = 0; k < 50 && bit_count != 4'd4; k++) @(negedge clk);
    check("rst.bit4", bit_count, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst.async", all_outs(), 0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst.idle", all_outs(), 0);
    check("rst.no_dv", dv_total - dv0, 0);
    @(posedge clk);
    #1;
    run_frame("post_rst", 8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized frames against the frame model.
    for (int i = 0; i < 16; i++) begin
      k  = $urandom_range(0, 2);
      p  = (k == 0) ? 8 : ((k == 1) ? 16 : 32);
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      pb = ($urandom_range(0, 3) != 0) ? ((^d) ^ pt) : ~((^d) ^ pt);
      sb = ($urandom_range(0, 6) != 0);
      run_frame($sformatf("rnd%0d", i), d, p, pe, pt, pb, sb);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
